// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, single-cycle ALU, iterative shift-add multiplier
// and the EXE/MEM pipeline register consumed by the MEM stage.
module exe_stage #(
    parameter int          DATA_W   = 32,
    parameter int          MUL_ITER = 32,
    parameter logic [3:0]  MUL_CMD  = 4'b1100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        EXE_CMD,
    input  logic [DATA_W-1:0] val1_ID,
    input  logic [DATA_W-1:0] val2_ID,
    input  logic [DATA_W-1:0] reg2_ID,
    input  logic [4:0]        dest_ID,
    input  logic              WB_En_ID,
    input  logic [1:0]        MEM_Signal_ID,
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [1:0]        sel_st,
    input  logic [DATA_W-1:0] ALU_result_MEM,
    input  logic [DATA_W-1:0] WB_value,
    output logic              stall_EXE,
    output logic              WB_En_EXE,
    output logic [1:0]        MEM_Signal_EXE,
    output logic [4:0]        dest_EXE,
    output logic [DATA_W-1:0] ALU_result_EXE,
    output logic [DATA_W-1:0] reg2_EXE
);
    localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc, r_mcand, r_mplr, r_st;
    logic [CNT_W-1:0]    r_count;
    logic [4:0]          r_dest;
    logic                r_wb_en;
    logic [1:0]          r_mem_sig;

    logic                r_wb_en_exe;
    logic [1:0]          r_mem_sig_exe;
    logic [4:0]          r_dest_exe;
    logic [DATA_W-1:0]   r_result_exe, r_reg2_exe;

    logic [DATA_W-1:0]   w_src1, w_src2, w_st, w_alu;
    logic [4:0]          w_shamt;
    logic                w_mul_start;

    // Code 11 is unused and falls back to the ID/EXE value.
    function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel,
                                              input logic [DATA_W-1:0] id_v,
                                              input logic [DATA_W-1:0] mem_v,
                                              input logic [DATA_W-1:0] wb_v);
        case (sel)
            2'b01:   fwd = mem_v;
            2'b10:   fwd = wb_v;
            default: fwd = id_v;
        endcase
    endfunction

    assign w_src1  = fwd(sel_src1, val1_ID, ALU_result_MEM, WB_value);
    assign w_src2  = fwd(sel_src2, val2_ID, ALU_result_MEM, WB_value);
    assign w_st    = fwd(sel_st,   reg2_ID, ALU_result_MEM, WB_value);
    assign w_shamt = w_src2[4:0];

    always_comb begin
        w_alu = '0;
        case (EXE_CMD)
            4'b0000: w_alu = w_src1 + w_src2;
            4'b0010: w_alu = w_src1 - w_src2;
            4'b0100: w_alu = w_src1 & w_src2;
            4'b0101: w_alu = w_src1 | w_src2;
            4'b0110: w_alu = ~(w_src1 | w_src2);
            4'b0111: w_alu = w_src1 ^ w_src2;
            4'b1000: w_alu = w_src1 << w_shamt;
            4'b1001: w_alu = w_src1 >> w_shamt;
            4'b1010: w_alu = $unsigned($signed(w_src1) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

    assign w_mul_start = (r_state == S_IDLE) && (EXE_CMD == MUL_CMD);
    // Gated by rst so upstream is released in the reset cycle itself.
    assign stall_EXE   = ~rst & (w_mul_start | (r_state == S_BUSY));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_mcand       <= '0;
            r_mplr        <= '0;
            r_st          <= '0;
            r_count       <= '0;
            r_dest        <= '0;
            r_wb_en       <= 1'b0;
            r_mem_sig     <= '0;
            r_wb_en_exe   <= 1'b0;
            r_mem_sig_exe <= '0;
            r_dest_exe    <= '0;
            r_result_exe  <= '0;
            r_reg2_exe    <= '0;
        end else begin
            // Bubble by default; overridden below when a real result is ready.
            r_wb_en_exe   <= 1'b0;
            r_mem_sig_exe <= '0;
            r_dest_exe    <= '0;
            r_result_exe  <= '0;
            r_reg2_exe    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_mul_start) begin
                        r_mcand   <= w_src1;
                        r_mplr    <= w_src2;
                        r_st      <= w_st;
                        r_dest    <= dest_ID;
                        r_wb_en   <= WB_En_ID;
                        r_mem_sig <= MEM_Signal_ID;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_state   <= S_BUSY;
                    end else begin
                        r_wb_en_exe   <= WB_En_ID;
                        r_mem_sig_exe <= MEM_Signal_ID;
                        r_dest_exe    <= dest_ID;
                        r_result_exe  <= w_alu;
                        r_reg2_exe    <= w_st;
                    end
                end
                S_BUSY: begin
                    if (r_mplr[0])
                        r_acc <= r_acc + r_mcand;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(MUL_ITER - 1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_wb_en_exe   <= r_wb_en;
                    r_mem_sig_exe <= r_mem_sig;
                    r_dest_exe    <= r_dest;
                    r_result_exe  <= r_acc;
                    r_reg2_exe    <= r_st;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign WB_En_EXE      = r_wb_en_exe;
    assign MEM_Signal_EXE = r_mem_sig_exe;
    assign dest_EXE       = r_dest_exe;
    assign ALU_result_EXE = r_result_exe;
    assign reg2_EXE       = r_reg2_exe;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: table of single-cycle ALU/forwarding vectors plus
// hand-written multiply, back-to-back and reset-abort sequences, checked via a scoreboard queue.
module tb_exe_stage;
    localparam int         DW   = 32;
    localparam int         ITER = 32;
    localparam logic [3:0] MUL  = 4'b1100;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] v1, v2, r2;
        logic [4:0]  dest;
        logic        wb;
        logic [1:0]  ms, s1, s2, st;
        logic [31:0] amem, wbv;
    } in_t;

    typedef struct packed {
        logic        wb;
        logic [1:0]  ms;
        logic [4:0]  dest;
        logic [31:0] res, r2;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    EXE_CMD = '0;
    logic [DW-1:0] val1_ID = '0, val2_ID = '0, reg2_ID = '0;
    logic [4:0]    dest_ID = '0;
    logic          WB_En_ID = 1'b0;
    logic [1:0]    MEM_Signal_ID = '0, sel_src1 = '0, sel_src2 = '0, sel_st = '0;
    logic [DW-1:0] ALU_result_MEM = '0, WB_value = '0;
    logic          stall_EXE, WB_En_EXE;
    logic [1:0]    MEM_Signal_EXE;
    logic [4:0]    dest_EXE;
    logic [DW-1:0] ALU_result_EXE, reg2_EXE;

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t sb[$];
    vec_t vecs[$];

    exe_stage #(.DATA_W(DW), .MUL_ITER(ITER), .MUL_CMD(MUL)) dut (
        .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD),
        .val1_ID(val1_ID), .val2_ID(val2_ID), .reg2_ID(reg2_ID),
        .dest_ID(dest_ID), .WB_En_ID(WB_En_ID), .MEM_Signal_ID(MEM_Signal_ID),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .sel_st(sel_st),
        .ALU_result_MEM(ALU_result_MEM), .WB_value(WB_value),
        .stall_EXE(stall_EXE), .WB_En_EXE(WB_En_EXE), .MEM_Signal_EXE(MEM_Signal_EXE),
        .dest_EXE(dest_EXE), .ALU_result_EXE(ALU_result_EXE), .reg2_EXE(reg2_EXE)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic [3:0] cmd, logic [31:0] v1, logic [31:0] v2,
                                  logic [31:0] r2, logic [4:0] dest, logic wb, logic [1:0] ms,
                                  logic [1:0] s1, logic [1:0] s2, logic [1:0] st,
                                  logic [31:0] amem, logic [31:0] wbv);
        in_t x;
        x = '{cmd, v1, v2, r2, dest, wb, ms, s1, s2, st, amem, wbv};
        return x;
    endfunction

    function automatic out_t mk_out(logic wb, logic [1:0] ms, logic [4:0] dest,
                                    logic [31:0] res, logic [31:0] r2);
        out_t o;
        o = '{wb, ms, dest, res, r2};
        return o;
    endfunction

    task automatic apply(input in_t x);
        EXE_CMD = x.cmd;  val1_ID = x.v1;  val2_ID = x.v2;  reg2_ID = x.r2;
        dest_ID = x.dest; WB_En_ID = x.wb; MEM_Signal_ID = x.ms;
        sel_src1 = x.s1;  sel_src2 = x.s2; sel_st = x.st;
        ALU_result_MEM = x.amem; WB_value = x.wbv;
    endtask

    task automatic check_out(input string nm);
        out_t e, a;
        n_tests++;
        a = '{WB_En_EXE, MEM_Signal_EXE, dest_EXE, ALU_result_EXE, reg2_EXE};
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got res=%h", nm, a.res);
        end else begin
            e = sb.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got wb=%b ms=%b dest=%0d res=%h r2=%h, want wb=%b ms=%b dest=%0d res=%h r2=%h",
                         nm, a.wb, a.ms, a.dest, a.res, a.r2, e.wb, e.ms, e.dest, e.res, e.r2);
            end else begin
                $display("[TB] %s: res=%h r2=%h dest=%0d wb=%b ms=%b ok", nm, a.res, a.r2, a.dest, a.wb, a.ms);
            end
        end
    endtask

    // One clock: drive at negedge, check stall mid-cycle, check EXE/MEM after the edge.
    task automatic cycle(input in_t x, input logic r, input out_t e, input logic exp_stall,
                         input string nm);
        @(negedge clk);
        rst = r;
        apply(x);
        sb.push_back(e);
        #1;
        n_tests++;
        if (stall_EXE !== exp_stall) begin
            n_fail++;
            $display("FAIL %s_stall: got %b want %b", nm, stall_EXE, exp_stall);
        end
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                           input logic [4:0] d, input logic wb, input logic [1:0] ms,
                           input string nm);
        in_t         x;
        logic [31:0] prod;
        prod = a * b;
        x = mk_in(MUL, a, b, 32'h0, d, wb, ms, 2'b00, 2'b00, 2'b10, 32'h0, st);
        for (int c = 0; c <= ITER + 1; c++) begin
            if (c > 0) begin
                // Operands and forwards must be ignored once the multiply is latched.
                x.v1 = $urandom; x.v2 = $urandom; x.r2 = $urandom;
                x.amem = $urandom; x.wbv = $urandom; x.dest = 5'd31;
            end
            if (c <= ITER)
                cycle(x, 1'b0, '0, 1'b1, $sformatf("%s_bubble%0d", nm, c));
            else
                cycle(x, 1'b0, mk_out(wb, ms, d, prod, st), 1'b0, $sformatf("%s_result", nm));
        end
    endtask

    initial begin
        in_t x;

        vecs.push_back('{"add", mk_in(4'b0000, 32'd5, 32'd7, 32'h0, 5'd3, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd3, 32'd12, 32'h0)});
        vecs.push_back('{"sub_fwd_mem", mk_in(4'b0010, 32'd100, 32'd10, 32'h0, 5'd4, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 32'd3, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd4, 32'hFFFFFFF9, 32'h0)});
        vecs.push_back('{"store_fwd_wb", mk_in(4'b0000, 32'h100, 32'd4, 32'h11111111, 5'd0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 32'h0, 32'hDEADBEEF),
                         mk_out(1'b0, 2'b01, 5'd0, 32'h104, 32'hDEADBEEF)});
        vecs.push_back('{"and", mk_in(4'b0100, 32'hF0F0, 32'hFF00, 32'h0, 5'd5, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd5, 32'hF000, 32'h0)});
        vecs.push_back('{"or", mk_in(4'b0101, 32'hF0F0, 32'h0F0F, 32'h0, 5'd6, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd6, 32'hFFFF, 32'h0)});
        vecs.push_back('{"nor", mk_in(4'b0110, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd7, 32'hFFFFFFFF, 32'h0)});
        vecs.push_back('{"xor", mk_in(4'b0111, 32'hAAAA5555, 32'hFFFF0000, 32'h0, 5'd8, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd8, 32'h55555555, 32'h0)});
        vecs.push_back('{"sll_31", mk_in(4'b1000, 32'h1, 32'h3F, 32'h0, 5'd9, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd9, 32'h80000000, 32'h0)});
        vecs.push_back('{"srl_31", mk_in(4'b1001, 32'h80000000, 32'd31, 32'h0, 5'd10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd10, 32'h1, 32'h0)});
        vecs.push_back('{"sra_4", mk_in(4'b1010, 32'h80000000, 32'd4, 32'h0, 5'd11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd11, 32'hF8000000, 32'h0)});
        vecs.push_back('{"undef_op", mk_in(4'b0011, 32'h1234, 32'h5678, 32'h0, 5'd12, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0),
                         mk_out(1'b1, 2'b00, 5'd12, 32'h0, 32'h0)});
        vecs.push_back('{"sel11_as_id", mk_in(4'b0000, 32'd10, 32'd20, 32'h77, 5'd13, 1'b1, 2'b00, 2'b11, 2'b11, 2'b11, 32'd1000, 32'd2000),
                         mk_out(1'b1, 2'b00, 5'd13, 32'd30, 32'h77)});
        vecs.push_back('{"fwd_wb_src2", mk_in(4'b0000, 32'd1, 32'd99, 32'h0, 5'd14, 1'b1, 2'b10, 2'b00, 2'b10, 2'b01, 32'hCAFE, 32'd5),
                         mk_out(1'b1, 2'b10, 5'd14, 32'd6, 32'hCAFE)});

        // Reset state: two cycles with rst high, outputs and stall must stay 0.
        x = mk_in(MUL, 32'd3, 32'd4, 32'h5, 5'd2, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        cycle(x, 1'b1, '0, 1'b0, "reset0");
        cycle(x, 1'b1, '0, 1'b0, "reset1");

        foreach (vecs[i])
            cycle(vecs[i].in, 1'b0, vecs[i].exp, 1'b0, vecs[i].name);

        run_mul(32'd7, 32'd6, 32'h0, 5'd17, 1'b1, 2'b00, "mul_7x6");
        run_mul(32'hFFFFFFFF, 32'd2, 32'h0, 5'd18, 1'b1, 2'b00, "mul_ffx2");
        run_mul(32'd3, 32'd3, 32'h0, 5'd19, 1'b1, 2'b00, "mul_3x3");
        run_mul(32'd12345, 32'd0, 32'h0, 5'd20, 1'b1, 2'b00, "mul_by0");
        run_mul(32'd5, 32'd5, 32'h0, 5'd21, 1'b0, 2'b00, "mul_nowb");
        run_mul(32'h12345678, 32'h9ABCDEF1, 32'hBEEF0001, 5'd22, 1'b0, 2'b01, "mul_store");

        // Reset abort: IDLE cycle + BUSY count 0..9, then rst while count=10.
        x = mk_in(MUL, 32'd9, 32'd9, 32'h0, 5'd23, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        for (int c = 0; c <= 10; c++)
            cycle(x, 1'b0, '0, 1'b1, $sformatf("abort_bubble%0d", c));
        cycle(x, 1'b1, '0, 1'b0, "abort_reset");
        x = mk_in(4'b0000, 32'd1, 32'd1, 32'h0, 5'd24, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        cycle(x, 1'b0, mk_out(1'b1, 2'b00, 5'd24, 32'd2, 32'h0), 1'b0, "add_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
